// File: rtl/phys_pkg.sv
// phys_pkg: shared vertical-physics constants, types and state encoding
package phys_pkg;
  localparam int G       = 14;
  localparam int V_JUMP  = 84;
  localparam int V_MAX   = 70;
  localparam int Y_CEIL  = 400;
  localparam int Y_SPAWN = 200;
  typedef logic [8:0] pos_t;
  typedef logic [8:0] vel_t;
  typedef enum logic [1:0] {
    ST_GROUND = 2'b00,
    ST_RISE   = 2'b01,
    ST_FALL   = 2'b10
  } state_t;
endpackage

// File: rtl/phys_step.sv
// phys_step: one physics tick of position/velocity, widened to 11-bit signed
module phys_step (
  input  logic [8:0]         y,
  input  logic [8:0]         v,
  input  logic [8:0]         g,
  output logic signed [10:0] y_n,
  output logic signed [10:0] v_n
);
  // y is unsigned, v is two's complement; the half-gravity term truncates toward zero
  always_comb begin
    y_n = $signed({2'b00, y} + {{2{v[8]}}, v} - {3'b000, g[8:1]});
    v_n = $signed({{2{v[8]}}, v} - {2'b00, g});
  end
endmodule

// File: rtl/jump_ctrl.sv
// jump_ctrl: player vertical motion FSM (ground, rise, fall) with landing pulse
module jump_ctrl
  import phys_pkg::*;
#(
  parameter int Y_CEIL_P = Y_CEIL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       jump_req,
  input  logic [8:0] y_floor,
  output logic [8:0] y,
  output logic [8:0] v,
  output logic       airborne,
  output logic       landed,
  output logic [1:0] state
);
  pos_t   y_q, y_d;
  vel_t   v_q, v_d;
  state_t state_q, state_d;
  logic   landed_q, landed_d, jmp_q, jmp_d, go;
  logic signed [10:0] y_n, v_n, v_clamp, floor_s;
  phys_step u_step (
    .y   (y_q),
    .v   (v_q),
    .g   (9'(G)),
    .y_n (y_n),
    .v_n (v_n)
  );
  // next-state: a request is remembered only until the next tick, consumed or not
  always_comb begin
    go       = jmp_q | jump_req;
    jmp_d    = tick ? 1'b0 : go;
    floor_s  = $signed({2'b00, y_floor});
    v_clamp  = (v_n < 11'(-V_MAX)) ? 11'(-V_MAX) : v_n;
    y_d      = y_q;
    v_d      = v_q;
    state_d  = state_q;
    landed_d = 1'b0;
    if (tick) begin
      case (state_q)
        ST_GROUND: begin
          if (go) begin
            v_d     = 9'(V_JUMP);
            state_d = ST_RISE;
          end else if (y_q > y_floor) begin
            v_d     = '0;
            state_d = ST_FALL;
          end else begin
            y_d = y_floor;
            v_d = '0;
          end
        end
        ST_RISE: begin
          if (y_n >= 11'(Y_CEIL_P)) begin
            y_d     = 9'(Y_CEIL_P);
            v_d     = '0;
            state_d = ST_FALL;
          end else begin
            y_d     = y_n[8:0];
            v_d     = v_n[8:0];
            state_d = (v_n <= 0) ? ST_FALL : ST_RISE;
          end
        end
        default: begin
          if (y_n <= floor_s) begin
            y_d      = y_floor;
            v_d      = '0;
            state_d  = ST_GROUND;
            landed_d = 1'b1;
          end else begin
            y_d     = y_n[8:0];
            v_d     = v_clamp[8:0];
            state_d = ST_FALL;
          end
        end
      endcase
    end
  end
  // state registers; reset drops the sprite back to spawn height in free fall
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= 9'(Y_SPAWN);
      v_q      <= '0;
      state_q  <= ST_FALL;
      landed_q <= 1'b0;
      jmp_q    <= 1'b0;
    end else begin
      y_q      <= y_d;
      v_q      <= v_d;
      state_q  <= state_d;
      landed_q <= landed_d;
      jmp_q    <= jmp_d;
    end
  end
  assign y        = y_q;
  assign v        = v_q;
  assign state    = state_q;
  assign landed   = landed_q;
  assign airborne = state_q != ST_GROUND;
endmodule

// File: tb/tb_jump_ctrl.sv
// tb_jump_ctrl: directed-vector self-checking bench for jump_ctrl
module tb_jump_ctrl;
  logic       clk = 1'b0;
  logic       rst, tick, jump_req;
  logic [8:0] y_floor, y, v;
  logic       airborne, landed;
  logic [1:0] state;
  int n_chk = 0;
  int n_pass = 0;
  int up_y[12] = '{97, 160, 209, 244, 265, 272, 265, 244, 209, 160, 97, 20};
  int fall_y[5] = '{193, 172, 137, 88, 25};
  int fall_v[5] = '{-14, -28, -42, -56, -70};
  jump_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .jump_req (jump_req),
    .y_floor  (y_floor),
    .y        (y),
    .v        (v),
    .airborne (airborne),
    .landed   (landed),
    .state    (state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic do_tick(input logic j);
    @(negedge clk);
    tick = 1'b1;
    jump_req = j;
    @(negedge clk);
    tick = 1'b0;
    jump_req = 1'b0;
  endtask
  task automatic pulse_jump();
    @(negedge clk);
    jump_req = 1'b1;
    @(negedge clk);
    jump_req = 1'b0;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_y"}, int'(y), 200);
    chk({tag, "_v"}, int'($signed(v)), 0);
    chk({tag, "_st"}, int'(state), 2);
    chk({tag, "_landed"}, int'(landed), 0);
    chk({tag, "_air"}, int'(airborne), 1);
  endtask
  initial begin
    rst = 1'b1;
    tick = 1'b0;
    jump_req = 1'b0;
    y_floor = 9'd0;
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_tick(1'b0);
      chk($sformatf("fall_y%0d", i), int'(y), fall_y[i]);
      chk($sformatf("fall_v%0d", i), int'($signed(v)), fall_v[i]);
      chk($sformatf("fall_l%0d", i), int'(landed), 0);
    end
    do_tick(1'b0);
    chk("land0_y", int'(y), 0);
    chk("land0_st", int'(state), 0);
    chk("land0_pulse", int'(landed), 1);
    chk("land0_air", int'(airborne), 0);
    @(negedge clk);
    chk("land0_pulse_off", int'(landed), 0);
    y_floor = 9'd20;
    do_tick(1'b0);
    chk("snap_y", int'(y), 20);
    chk("snap_st", int'(state), 0);
    pulse_jump();
    do_tick(1'b0);
    chk("launch_st", int'(state), 1);
    chk("launch_v", int'($signed(v)), 84);
    chk("launch_y", int'(y), 20);
    for (int i = 0; i < 12; i++) begin
      if (i == 1) pulse_jump();
      do_tick(1'b0);
      chk($sformatf("arc_y%0d", i), int'(y), up_y[i]);
      if (i == 5) begin
        chk("apex_st", int'(state), 2);
        chk("apex_v", int'($signed(v)), 0);
      end
      if (i < 11) chk($sformatf("arc_l%0d", i), int'(landed), 0);
    end
    chk("arc_land_st", int'(state), 0);
    chk("arc_land_pulse", int'(landed), 1);
    do_tick(1'b0);
    chk("latch_clear_st", int'(state), 0);
    chk("latch_clear_y", int'(y), 20);
    y_floor = 9'd300;
    do_tick(1'b0);
    chk("snap300_y", int'(y), 300);
    pulse_jump();
    do_tick(1'b0);
    chk("ceil_launch_st", int'(state), 1);
    do_tick(1'b0);
    chk("ceil_t1_y", int'(y), 377);
    chk("ceil_t1_v", int'($signed(v)), 70);
    do_tick(1'b0);
    chk("ceil_bump_y", int'(y), 400);
    chk("ceil_bump_v", int'($signed(v)), 0);
    chk("ceil_bump_st", int'(state), 2);
    do_tick(1'b0);
    chk("ceil_f1_y", int'(y), 393);
    do_tick(1'b0);
    do_tick(1'b0);
    chk("ceil_f3_y", int'(y), 337);
    do_tick(1'b0);
    chk("ceil_land_y", int'(y), 300);
    chk("ceil_land_pulse", int'(landed), 1);
    y_floor = 9'd0;
    do_tick(1'b0);
    chk("ledge_st", int'(state), 2);
    chk("ledge_v", int'($signed(v)), 0);
    chk("ledge_y", int'(y), 300);
    do_tick(1'b0);
    chk("ledge_f_y", int'(y), 293);
    chk("ledge_f_v", int'($signed(v)), -14);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst1");
    y_floor = 9'd20;
    repeat (6) do_tick(1'b0);
    chk("reland_y", int'(y), 20);
    chk("reland_st", int'(state), 0);
    y_floor = 9'd0;
    do_tick(1'b1);
    chk("jdrop_st", int'(state), 1);
    chk("jdrop_v", int'($signed(v)), 84);
    chk("jdrop_y", int'(y), 20);
    for (int i = 0; i < 3; i++) do_tick(1'b0);
    chk("mid_rise_y", int'(y), 209);
    chk("mid_rise_st", int'(state), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst2");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
